byteswap_axi_read_master: RTL and testbench

- Upstream read stage of the byteswap kernel datapath.
- On a start pulse, fetches a contiguous buffer from global memory over the m00 AXI4 read channels as aligned bursts.
- Presents the returned beats as an AXI4-Stream to the byteswap swap stage, with tlast on the final beat.
- Reports completion to the kernel controller with a one-cycle done pulse.

---
 rtl/byteswap_pkg.sv | 18 +
 rtl/byteswap_burst_len.sv | 31 +++
 rtl/byteswap_axi_read_master.sv | 192 +++++++++++++++++++
 tb/tb_byteswap_axi_read_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/byteswap_pkg.sv
// Shared constants and state encoding for the byteswap read master.
// Beat geometry assumes the default 512-bit AXI data path.
package byteswap_pkg;

   localparam int unsigned DATA_WIDTH     = 32'd512;
   localparam int unsigned BPB            = DATA_WIDTH / 32'd8;
   localparam int unsigned LOG2_BPB       = $clog2(BPB);
   localparam int unsigned BOUNDARY_BITS  = 32'd12;
   localparam int unsigned PAGE_BEAT_BITS = BOUNDARY_BITS - LOG2_BPB;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/byteswap_burst_len.sv
// Combinational burst sizing: the shortest of remaining beats, the
// configured maximum burst, and the beats left before the next 4 KB page.
module byteswap_burst_len
   import byteswap_pkg::*;
#(
   parameter int C_XFER_SIZE_WIDTH = 32,
   parameter int C_MAX_BURST_LEN   = 64
) (
   input  logic [C_XFER_SIZE_WIDTH-1:0] rem_beats,
   input  logic [PAGE_BEAT_BITS-1:0]    page_beat,
   output logic [7:0]                   arlen
);

   localparam int XW = C_XFER_SIZE_WIDTH;
   localparam logic [XW-1:0] MAX_LEN    = XW'(C_MAX_BURST_LEN);
   localparam logic [XW-1:0] PAGE_BEATS = XW'(32'd1 << PAGE_BEAT_BITS);
   localparam logic [XW-1:0] X_ONE      = XW'(32'd1);

   logic [XW-1:0] to_bound_s;
   logic [XW-1:0] cap_s;
   logic [XW-1:0] len_s;

   // min of the three limits; page_beat is the beat index inside the 4 KB page
   always_comb begin
      to_bound_s = PAGE_BEATS - XW'(page_beat);
      cap_s      = (MAX_LEN < to_bound_s) ? MAX_LEN : to_bound_s;
      len_s      = (rem_beats < cap_s) ? rem_beats : cap_s;
      arlen      = 8'(len_s - X_ONE);
   end

endmodule

// File: rtl/byteswap_axi_read_master.sv
// Read master: fetches a contiguous buffer as 4 KB-safe AXI4 bursts and
// forwards the read data as an AXI4-Stream with tlast on the final beat.
module byteswap_axi_read_master
   import byteswap_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_MAX_BURST_LEN    = 64,
   parameter int C_MAX_OUTSTANDING  = 4
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           ctrl_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]  ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]   ctrl_xfer_size_in_bytes,
   output logic                           ctrl_done,
   output logic                           m_axi_arvalid,
   input  logic                           m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [7:0]                     m_axi_arlen,
   input  logic                           m_axi_rvalid,
   output logic                           m_axi_rready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic                           m_axi_rlast,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                           m_axis_tlast
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int XW = C_XFER_SIZE_WIDTH;
   localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

   localparam logic [AW-1:0] ADDR_MASK = ~AW'(BPB - 32'd1);
   localparam logic [AW-1:0] A_ONE     = AW'(32'd1);
   localparam logic [XW-1:0] X_ZERO    = XW'(32'd0);
   localparam logic [XW-1:0] X_ONE     = XW'(32'd1);
   localparam logic [OW-1:0] O_ONE     = OW'(32'd1);
   localparam logic [OW-1:0] O_MAX     = OW'(C_MAX_OUTSTANDING);

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XW-1:0]   ar_rem_q, ar_rem_d;
   logic [XW-1:0]   r_rem_q, r_rem_d;
   logic [OW-1:0]   out_q, out_d;
   logic            arvalid_q, arvalid_d;
   logic [7:0]      arlen_q, arlen_d;
   logic            done_q, done_d;

   logic            active_s;
   logic            ar_hs_s;
   logic            r_hs_s;
   logic            rlast_hs_s;
   logic [XW-1:0]   start_beats_s;
   logic [AW-1:0]   nxt_addr_s;
   logic [XW-1:0]   nxt_rem_s;
   logic [7:0]      bl_arlen_s;

   assign active_s   = (state_q == RUN) || (state_q == DRAIN);
   assign ar_hs_s    = arvalid_q & m_axi_arready;
   assign r_hs_s     = active_s & m_axi_rvalid & m_axis_tready;
   assign rlast_hs_s = r_hs_s & m_axi_rlast;

   assign ctrl_done     = done_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_rready  = active_s & m_axis_tready;
   assign m_axis_tvalid = active_s & m_axi_rvalid;
   assign m_axis_tdata  = m_axi_rdata;
   assign m_axis_tlast  = (r_rem_q == X_ONE);

   // Address and remaining AR beats as they will stand after this cycle;
   // the next burst is sized from these so it can be issued back-to-back.
   always_comb begin
      start_beats_s = (ctrl_xfer_size_in_bytes >> LOG2_BPB)
                    + XW'(|ctrl_xfer_size_in_bytes[LOG2_BPB-1:0]);
      if (state_q == IDLE) begin
         nxt_addr_s = ctrl_addr_offset & ADDR_MASK;
         nxt_rem_s  = start_beats_s;
      end else if (ar_hs_s) begin
         nxt_addr_s = addr_q + ((AW'(arlen_q) + A_ONE) << LOG2_BPB);
         nxt_rem_s  = ar_rem_q - (XW'(arlen_q) + X_ONE);
      end else begin
         nxt_addr_s = addr_q;
         nxt_rem_s  = ar_rem_q;
      end
   end

   byteswap_burst_len #(
      .C_XFER_SIZE_WIDTH (C_XFER_SIZE_WIDTH),
      .C_MAX_BURST_LEN   (C_MAX_BURST_LEN)
   ) u_burst_len (
      .rem_beats (nxt_rem_s),
      .page_beat (nxt_addr_s[BOUNDARY_BITS-1:LOG2_BPB]),
      .arlen     (bl_arlen_s)
   );

   // Outstanding-burst count: up on AR handshake, down on the rlast handshake
   always_comb begin
      if (ar_hs_s && !rlast_hs_s) begin
         out_d = out_q + O_ONE;
      end else if (!ar_hs_s && rlast_hs_s) begin
         out_d = out_q - O_ONE;
      end else begin
         out_d = out_q;
      end
   end

   // FSM next state and AR channel; arvalid reflects next-cycle outstanding
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ar_rem_d  = ar_rem_q;
      r_rem_d   = r_hs_s ? (r_rem_q - X_ONE) : r_rem_q;
      arvalid_d = arvalid_q;
      arlen_d   = arlen_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (ctrl_start) begin
               if (start_beats_s == X_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d   = RUN;
                  addr_d    = nxt_addr_s;
                  ar_rem_d  = nxt_rem_s;
                  r_rem_d   = nxt_rem_s;
                  arvalid_d = 1'b1;
                  arlen_d   = bl_arlen_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            addr_d   = nxt_addr_s;
            ar_rem_d = nxt_rem_s;
            if (nxt_rem_s == X_ZERO) begin
               arvalid_d = 1'b0;
               state_d   = DRAIN;
            end else if (arvalid_q && !m_axi_arready) begin
               arvalid_d = 1'b1;
            end else begin
               arvalid_d = (out_d < O_MAX);
               arlen_d   = bl_arlen_s;
            end
         end
         DRAIN: begin
            if (r_hs_s && (r_rem_q == X_ONE)) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= IDLE;
         addr_q    <= {AW{1'b0}};
         ar_rem_q  <= {XW{1'b0}};
         r_rem_q   <= {XW{1'b0}};
         out_q     <= {OW{1'b0}};
         arvalid_q <= 1'b0;
         arlen_q   <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         ar_rem_q  <= ar_rem_d;
         r_rem_q   <= r_rem_d;
         out_q     <= out_d;
         arvalid_q <= arvalid_d;
         arlen_q   <= arlen_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_byteswap_axi_read_master.sv
// Directed bench with a reactive AXI read slave and a stream scoreboard.
module tb_byteswap_axi_read_master;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   addr_in = 64'd0;
   logic [31:0]   size_in = 32'd0;
   logic          done;
   logic          arvalid;
   logic          arready = 1'b1;
   logic [63:0]   araddr;
   logic [7:0]    arlen;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [511:0]  rdata = 512'd0;
   logic          rlast = 1'b0;
   logic          tvalid;
   logic          tready = 1'b1;
   logic [511:0]  tdata;
   logic          tlast;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int ar_cnt = 0;
   int beat_cnt = 0;
   int out_bench = 0;
   int ar_mode = 0;
   int r_mode = 0;
   int t_mode = 0;

   logic [63:0]  exp_ar_addr[$];
   logic [7:0]   exp_ar_len[$];
   logic [511:0] exp_data[$];
   logic         exp_last[$];
   logic [63:0]  sl_q_addr[$];
   logic [7:0]   sl_q_len[$];
   logic         sl_busy = 1'b0;
   logic [63:0]  sl_addr = 64'd0;
   logic [7:0]   sl_len = 8'd0;
   logic [7:0]   sl_idx = 8'd0;
   logic         ar_fire_n = 1'b0;
   logic         r_fire_n = 1'b0;

   byteswap_axi_read_master dut (
      .ap_clk                  (clk),
      .ap_rst_n                (rst_n),
      .ctrl_start              (start),
      .ctrl_addr_offset        (addr_in),
      .ctrl_xfer_size_in_bytes (size_in),
      .ctrl_done               (done),
      .m_axi_arvalid           (arvalid),
      .m_axi_arready           (arready),
      .m_axi_araddr            (araddr),
      .m_axi_arlen             (arlen),
      .m_axi_rvalid            (rvalid),
      .m_axi_rready            (rready),
      .m_axi_rdata             (rdata),
      .m_axi_rlast             (rlast),
      .m_axis_tvalid           (tvalid),
      .m_axis_tready           (tready),
      .m_axis_tdata            (tdata),
      .m_axis_tlast            (tlast)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] pat(input logic [63:0] a);
      logic [511:0] r;
      for (int k = 0; k < 8; k++) begin
         r[k*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF * 64'(k + 1));
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are decided here, half a cycle before the edge that completes them
   always @(negedge clk) begin
      ar_fire_n = rst_n && arvalid && arready;
      r_fire_n  = rst_n && rvalid && rready;
      if (done) done_cnt++;
      if (ar_fire_n) begin
         ar_cnt++;
         chk("ar_outstanding_limit", 512'(out_bench < 4), 512'(1));
         chk("ar_expected", 512'(exp_ar_addr.size() != 0), 512'(1));
         if (exp_ar_addr.size() != 0) begin
            chk("araddr", 512'(araddr), 512'(exp_ar_addr.pop_front()));
            chk("arlen", 512'(arlen), 512'(exp_ar_len.pop_front()));
         end
         sl_q_addr.push_back(araddr);
         sl_q_len.push_back(arlen);
         out_bench++;
      end
      if (r_fire_n && rlast) out_bench--;
      if (rst_n && tvalid && tready) begin
         beat_cnt++;
         chk("rready_follows_tready", 512'(rready), 512'(1));
         chk("beat_expected", 512'(exp_data.size() != 0), 512'(1));
         if (exp_data.size() != 0) begin
            chk("tdata", tdata, exp_data.pop_front());
            chk("tlast", 512'(tlast), 512'(exp_last.pop_front()));
         end
      end
   end

   // Reactive read slave plus random ready generation
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         sl_q_addr.delete();
         sl_q_len.delete();
         sl_busy = 1'b0;
         rvalid  = 1'b0;
         rlast   = 1'b0;
      end else begin
         if (r_fire_n) begin
            if (sl_idx == sl_len) sl_busy = 1'b0;
            else sl_idx = sl_idx + 8'd1;
         end
         if (!sl_busy && sl_q_addr.size() != 0) begin
            sl_addr = sl_q_addr.pop_front();
            sl_len  = sl_q_len.pop_front();
            sl_idx  = 8'd0;
            sl_busy = 1'b1;
         end
         if (!(rvalid && !r_fire_n)) begin
            rvalid = sl_busy && ((r_mode == 0) || ((r_mode == 1) && ($urandom_range(0, 3) != 0)));
         end
         rdata = pat(sl_addr + (64'(sl_idx) << 6));
         rlast = (sl_idx == sl_len);
      end
      arready = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tready  = (t_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
   end

   task automatic push_ar(input logic [63:0] a, input logic [7:0] l);
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(l);
   endtask

   task automatic push_ar_model(input logic [63:0] a, input int beats);
      int rem = beats;
      int len;
      int tb;
      logic [63:0] p = a;
      while (rem > 0) begin
         tb  = (4096 - int'(p[11:0])) / 64;
         len = (rem < 64) ? rem : 64;
         len = (len < tb) ? len : tb;
         push_ar(p, 8'(len - 1));
         p   = p + 64'(len * 64);
         rem = rem - len;
      end
   endtask

   task automatic push_beats(input logic [63:0] a, input int beats);
      for (int i = 0; i < beats; i++) begin
         exp_data.push_back(pat(a + 64'(i * 64)));
         exp_last.push_back(i == beats - 1);
      end
   endtask

   task automatic pulse_start(input logic [63:0] a, input logic [31:0] s);
      @(posedge clk); #1;
      start = 1'b1; addr_in = a; size_in = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_xfer(input int d0, input int b0, input int beats, input int budget);
      for (int n = 0; n < budget && done_cnt == d0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 512'(done_cnt - d0), 512'(1));
      chk("beat_count", 512'(beat_cnt - b0), 512'(beats));
      chk("beats_left", 512'(exp_data.size()), 512'(0));
      chk("ars_left", 512'(exp_ar_addr.size()), 512'(0));
   endtask

   task automatic run_xfer(input logic [63:0] a, input logic [31:0] s, input int budget);
      int beats = (int'(s) + 63) / 64;
      int d0 = done_cnt;
      int b0 = beat_cnt;
      push_beats(a, beats);
      pulse_start(a, s);
      if (beats > 0) chk("first_ar_latency", 512'(arvalid), 512'(1));
      finish_xfer(d0, b0, beats, budget);
   endtask

   initial begin
      int a0;
      int d0;
      int b0;
      #2;
      chk("rst_arvalid", 512'(arvalid), 512'(0));
      chk("rst_done", 512'(done), 512'(0));
      chk("rst_tvalid", 512'(tvalid), 512'(0));
      chk("rst_rready", 512'(rready), 512'(0));
      chk("rst_araddr", 512'(araddr), 512'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // zero length: done exactly in the second cycle after start, no AR
      a0 = ar_cnt;
      pulse_start(64'h0, 32'd0);
      chk("zero_done_c1", 512'(done), 512'(0));
      chk("zero_arvalid", 512'(arvalid), 512'(0));
      @(posedge clk); #1;
      chk("zero_done_c2", 512'(done), 512'(1));
      @(posedge clk); #1;
      chk("zero_done_c3", 512'(done), 512'(0));
      chk("zero_no_ar", 512'(ar_cnt - a0), 512'(0));

      push_ar(64'h0, 8'd0);
      run_xfer(64'h0, 32'd64, 200);

      push_ar(64'h0, 8'd1);
      run_xfer(64'h0, 32'd100, 200);

      push_ar(64'h0, 8'd63);
      push_ar(64'h1000, 8'd63);
      run_xfer(64'h0, 32'd8192, 1000);

      push_ar(64'hFC0, 8'd0);
      push_ar(64'h1000, 8'd2);
      run_xfer(64'hFC0, 32'd256, 200);

      // outstanding limit with the R channel stalled, then released
      r_mode = 2;
      a0 = ar_cnt; d0 = done_cnt; b0 = beat_cnt;
      push_ar_model(64'h10000, 1024);
      push_beats(64'h10000, 1024);
      pulse_start(64'h10000, 32'd65536);
      repeat (20) @(posedge clk);
      #1;
      chk("outstanding_ar_count", 512'(ar_cnt - a0), 512'(4));
      chk("outstanding_arvalid_low", 512'(arvalid), 512'(0));
      r_mode = 0; t_mode = 1;
      finish_xfer(d0, b0, 1024, 6000);

      // random gaps on every channel, unaligned-to-page start
      ar_mode = 1; r_mode = 1; t_mode = 1;
      push_ar_model(64'h3F40, 79);
      run_xfer(64'h3F40, 32'd5000, 3000);
      ar_mode = 0; r_mode = 0; t_mode = 0;

      // reset in the middle of a transfer, then a clean transfer
      push_ar_model(64'h0, 128);
      push_beats(64'h0, 128);
      pulse_start(64'h0, 32'd8192);
      repeat (30) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_arvalid", 512'(arvalid), 512'(0));
      chk("midrst_tvalid", 512'(tvalid), 512'(0));
      chk("midrst_rready", 512'(rready), 512'(0));
      chk("midrst_done", 512'(done), 512'(0));
      exp_ar_addr.delete(); exp_ar_len.delete();
      exp_data.delete(); exp_last.delete();
      out_bench = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      push_ar(64'h2000, 8'd1);
      run_xfer(64'h2000, 32'd100, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
